// File: rtl/block_program_loader_if.sv
// Bus bundle between the program loader, its source image memory and the
// processing-element block host MMIO port.
interface block_program_loader_if #(
  parameter int unsigned INDEX_WIDTH = 16,
  parameter int unsigned DATA_WIDTH  = 32
);
  logic                   source_read_req;
  logic [INDEX_WIDTH-1:0] source_read_index;
  logic                   source_read_ack;
  logic [DATA_WIDTH-1:0]  source_read_data;

  logic                   host_write_req;
  logic [INDEX_WIDTH-1:0] host_write_index;
  logic [DATA_WIDTH-1:0]  host_write_data;
  logic                   host_write_ack;

  modport master (
    output source_read_req, source_read_index,
    input  source_read_ack, source_read_data,
    output host_write_req, host_write_index, host_write_data,
    input  host_write_ack
  );

  modport slave (
    input  source_read_req, source_read_index,
    output source_read_ack, source_read_data,
    input  host_write_req, host_write_index, host_write_data,
    output host_write_ack
  );
endinterface

// File: rtl/block_program_loader.sv
// Streams a program image (instructions, then router settings) into the PE
// block over its host port, runs the block and reports done or timeout.
module block_program_loader #(
  parameter int unsigned NUM_PES           = 16,
  parameter int unsigned INSTRUCTION_WORDS = 8,
  parameter int unsigned ROUTER_WORDS      = 2,
  parameter int unsigned PE_SPACE_WORDS    = 64,
  parameter int unsigned INSTRUCTION_BASE  = 0,
  parameter int unsigned ROUTER_BASE       = 32,
  parameter int unsigned INDEX_WIDTH       = 16,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned TIMEOUT_CYCLES    = 1000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  block_program_loader_if.master bus,
  output logic                   block_enable,
  output logic                   block_execute,
  input  logic                   block_halted,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [31:0]            run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_ENABLE, S_FETCH, S_WRITE, S_START, S_RUN, S_DONE, S_ERROR
  } state_t;

  state_t                 state_reg, state_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic                   error_reg, error_next;
  logic                   enable_reg, enable_next;
  logic                   execute_reg, execute_next;
  logic [31:0]            run_cycles_reg, run_cycles_next;
  logic                   src_req_reg, src_req_next;
  logic [INDEX_WIDTH-1:0] src_index_reg, src_index_next;
  logic                   host_req_reg, host_req_next;
  logic [INDEX_WIDTH-1:0] host_index_reg, host_index_next;
  logic [DATA_WIDTH-1:0]  host_data_reg, host_data_next;
  logic                   router_phase_reg, router_phase_next;
  logic [31:0]            pe_count_reg, pe_count_next;
  logic [31:0]            word_count_reg, word_count_next;
  logic [31:0]            src_count_reg, src_count_next;

  logic [31:0] words_per_pe;
  logic [31:0] slot_base;
  logic [31:0] run_inc;
  logic        last_word;
  logic        last_pe;

  // PEs sit in 2x2 quartets; memory-map slot is quartet-major, then sub-position.
  function automatic logic [31:0] slot_of(input logic [31:0] pe);
    logic [31:0] row;
    logic [31:0] col;
    row = pe / 4;
    col = pe % 4;
    return 4 * (2 * (row / 2) + col / 2) + 2 * (row % 2) + col % 2;
  endfunction

  // The source image is contiguous in load order, so a linear counter addresses it.
  assign words_per_pe = router_phase_reg ? ROUTER_WORDS : INSTRUCTION_WORDS;
  assign last_word    = (word_count_reg == words_per_pe - 1);
  assign last_pe      = (pe_count_reg == NUM_PES - 1);
  assign slot_base    = PE_SPACE_WORDS * slot_of(pe_count_reg)
                        + (router_phase_reg ? ROUTER_BASE : INSTRUCTION_BASE);
  assign run_inc      = (run_cycles_reg == 32'hFFFF_FFFF) ? run_cycles_reg
                                                          : run_cycles_reg + 32'd1;

  always_comb begin
    state_next        = state_reg;
    busy_next         = busy_reg;
    done_next         = done_reg;
    error_next        = error_reg;
    enable_next       = enable_reg;
    execute_next      = execute_reg;
    run_cycles_next   = run_cycles_reg;
    src_req_next      = src_req_reg;
    src_index_next    = src_index_reg;
    host_req_next     = host_req_reg;
    host_index_next   = host_index_reg;
    host_data_next    = host_data_reg;
    router_phase_next = router_phase_reg;
    pe_count_next     = pe_count_reg;
    word_count_next   = word_count_reg;
    src_count_next    = src_count_reg;

    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          busy_next         = 1'b1;
          done_next         = 1'b0;
          error_next        = 1'b0;
          run_cycles_next   = 32'd0;
          router_phase_next = 1'b0;
          pe_count_next     = 32'd0;
          word_count_next   = 32'd0;
          src_count_next    = 32'd0;
          state_next        = S_ENABLE;
        end
      end

      S_ENABLE: begin
        enable_next = 1'b1;
        state_next  = S_FETCH;
      end

      S_FETCH: begin
        if (!src_req_reg) begin
          src_req_next   = 1'b1;
          src_index_next = INDEX_WIDTH'(src_count_reg);
        end else if (bus.source_read_ack) begin
          src_req_next    = 1'b0;
          host_data_next  = bus.source_read_data;
          host_index_next = INDEX_WIDTH'(slot_base + word_count_reg);
          state_next      = S_WRITE;
        end
      end

      S_WRITE: begin
        if (!host_req_reg) begin
          host_req_next = 1'b1;
        end else if (bus.host_write_ack) begin
          host_req_next  = 1'b0;
          src_count_next = src_count_reg + 32'd1;
          state_next     = S_FETCH;
          if (!last_word) begin
            word_count_next = word_count_reg + 32'd1;
          end else begin
            word_count_next = 32'd0;
            if (!last_pe) begin
              pe_count_next = pe_count_reg + 32'd1;
            end else begin
              pe_count_next = 32'd0;
              if (!router_phase_reg && ROUTER_WORDS != 0) begin
                router_phase_next = 1'b1;
              end else begin
                execute_next = 1'b1;
                state_next   = S_START;
              end
            end
          end
        end
      end

      S_START: begin
        run_cycles_next = run_inc;
        state_next      = S_RUN;
      end

      S_RUN: begin
        // The halting cycle itself is not counted; halt beats a coincident timeout.
        if (block_halted) begin
          execute_next = 1'b0;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          state_next   = S_DONE;
        end else begin
          run_cycles_next = run_inc;
          if (run_inc >= TIMEOUT_CYCLES) begin
            execute_next = 1'b0;
            error_next   = 1'b1;
            busy_next    = 1'b0;
            state_next   = S_ERROR;
          end
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg        <= S_IDLE;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
      enable_reg       <= 1'b0;
      execute_reg      <= 1'b0;
      run_cycles_reg   <= 32'd0;
      src_req_reg      <= 1'b0;
      src_index_reg    <= '0;
      host_req_reg     <= 1'b0;
      host_index_reg   <= '0;
      host_data_reg    <= '0;
      router_phase_reg <= 1'b0;
      pe_count_reg     <= 32'd0;
      word_count_reg   <= 32'd0;
      src_count_reg    <= 32'd0;
    end else begin
      state_reg        <= state_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      error_reg        <= error_next;
      enable_reg       <= enable_next;
      execute_reg      <= execute_next;
      run_cycles_reg   <= run_cycles_next;
      src_req_reg      <= src_req_next;
      src_index_reg    <= src_index_next;
      host_req_reg     <= host_req_next;
      host_index_reg   <= host_index_next;
      host_data_reg    <= host_data_next;
      router_phase_reg <= router_phase_next;
      pe_count_reg     <= pe_count_next;
      word_count_reg   <= word_count_next;
      src_count_reg    <= src_count_next;
    end
  end

  assign bus.source_read_req   = src_req_reg;
  assign bus.source_read_index = src_index_reg;
  assign bus.host_write_req    = host_req_reg;
  assign bus.host_write_index  = host_index_reg;
  assign bus.host_write_data   = host_data_reg;
  assign block_enable          = enable_reg;
  assign block_execute         = execute_reg;
  assign busy                  = busy_reg;
  assign done                  = done_reg;
  assign error                 = error_reg;
  assign run_cycles            = run_cycles_reg;

endmodule

// File: tb/tb_block_program_loader.sv
// Directed bench: source and host responders around the loader, expected
// writes held in a scoreboard queue and popped as each write is accepted.
module tb_block_program_loader;

  localparam int IMAGE_WORDS = 160;

  typedef struct {
    int          src;
    int          host;
    logic [31:0] data;
  } exp_t;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic        halted;
  logic        enable;
  logic        execute;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] run_cycles;

  block_program_loader_if #(.INDEX_WIDTH(16), .DATA_WIDTH(32)) bus ();

  block_program_loader #(
    .NUM_PES(16), .INSTRUCTION_WORDS(8), .ROUTER_WORDS(2), .PE_SPACE_WORDS(64),
    .INSTRUCTION_BASE(0), .ROUTER_BASE(32), .INDEX_WIDTH(16), .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clock(clock), .reset(rst_n), .start(start), .bus(bus),
    .block_enable(enable), .block_execute(execute), .block_halted(halted),
    .busy(busy), .done(done), .error(error), .run_cycles(run_cycles)
  );

  logic [31:0] src_mem [IMAGE_WORDS];
  exp_t        sb [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          host_writes = 0;
  int          last_ack_cycle = 0;
  bit          stall = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source memory responder
  int s_delay = 0;
  bit s_wait = 0;
  initial begin
    bus.source_read_ack  = 1'b0;
    bus.source_read_data = '0;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        bus.source_read_ack = 1'b0;
        s_wait = 0;
      end else if (bus.source_read_ack) begin
        bus.source_read_ack = 1'b0;
        s_wait = 0;
      end else if (bus.source_read_req) begin
        if (!s_wait) begin
          s_wait = 1;
          s_delay = stall ? int'($urandom_range(0, 7)) : 0;
        end
        if (s_delay == 0) begin
          bus.source_read_ack  = 1'b1;
          bus.source_read_data = (int'(bus.source_read_index) < IMAGE_WORDS)
                                 ? src_mem[int'(bus.source_read_index)] : 32'hBAD0_0000;
        end else begin
          s_delay--;
        end
      end
    end
  end

  // Host port responder and scoreboard consumer
  int          h_delay = 0;
  bit          h_wait = 0;
  logic [15:0] h_idx;
  logic [31:0] h_dat;
  initial begin
    bus.host_write_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        bus.host_write_ack = 1'b0;
        h_wait = 0;
      end else if (bus.host_write_ack) begin
        bus.host_write_ack = 1'b0;
        h_wait = 0;
      end else if (bus.host_write_req) begin
        if (!h_wait) begin
          h_wait = 1;
          h_idx = bus.host_write_index;
          h_dat = bus.host_write_data;
          h_delay = stall ? int'($urandom_range(0, 7)) : 0;
        end else begin
          check("hold_index", bus.host_write_index, h_idx);
          check("hold_data", bus.host_write_data, h_dat);
        end
        if (h_delay == 0) begin
          exp_t e;
          bus.host_write_ack = 1'b1;
          last_ack_cycle = cyc + 1;
          check("sb_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("write %0d: index=%0d data=%08h (source %0d)",
                     host_writes, bus.host_write_index, bus.host_write_data, e.src);
            check("write_index", bus.host_write_index, e.host);
            check("write_data", bus.host_write_data, e.data);
            if (e.src == 43) check("slot_pe5_k3", bus.host_write_index, 195);
            if (e.src == 141) check("slot_pe6_r1", bus.host_write_index, 417);
          end
          host_writes++;
        end else begin
          h_delay--;
        end
      end
    end
  end

  task automatic push_image();
    int row, col, m;
    sb.delete();
    host_writes = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int p = 0; p < 16; p++) begin
        row = p / 4;
        col = p % 4;
        m = 4 * (2 * (row / 2) + col / 2) + 2 * (row % 2) + col % 2;
        for (int k = 0; k < (ph == 0 ? 8 : 2); k++) begin
          exp_t e;
          e.src  = (ph == 0) ? p * 8 + k : 128 + p * 2 + k;
          e.host = 64 * m + ((ph == 0) ? 0 : 32) + k;
          e.data = src_mem[e.src];
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_exec(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (execute) break;
      @(negedge clock);
    end
    check("exec_rise_in_budget", execute, 1);
  endtask

  task automatic halt_after_50(input string tag);
    repeat (50) @(negedge clock);
    halted = 1'b1;
    @(negedge clock);
    halted = 1'b0;
    $display("%s: done=%0d error=%0d run_cycles=%0d", tag, done, error, run_cycles);
    check({tag, "_done"}, done, 1);
    check({tag, "_error"}, error, 0);
    check({tag, "_execute"}, execute, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_run_cycles"}, run_cycles, 50);
    check({tag, "_enable_held"}, enable, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_enable"}, enable, 0);
    check({tag, "_execute"}, execute, 0);
    check({tag, "_run_cycles"}, run_cycles, 0);
    check({tag, "_src_req"}, bus.source_read_req, 0);
    check({tag, "_host_req"}, bus.host_write_req, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    halted = 1'b0;
    for (int i = 0; i < IMAGE_WORDS; i++) src_mem[i] = $urandom;

    repeat (3) @(negedge clock);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clock);
    check("idle_busy", busy, 0);

    // Run A: single-cycle acks, halt after 50 run cycles
    push_image();
    pulse_start();
    check("start_busy_t1", busy, 1);
    check("start_enable_t1", enable, 0);
    @(negedge clock);
    check("start_enable_t2", enable, 1);
    wait_exec(5000);
    check("a_writes", host_writes, IMAGE_WORDS);
    check("a_sb_empty", sb.size(), 0);
    check("a_exec_after_last_ack", cyc, last_ack_cycle);
    halt_after_50("a");

    // Run B: stalled acks, restart from DONE, start while busy is ignored
    stall = 1;
    push_image();
    pulse_start();
    for (int i = 0; i < 5000 && host_writes < 20; i++) @(negedge clock);
    check("b_reached_20", host_writes >= 20, 1);
    pulse_start();
    wait_exec(30000);
    check("b_writes", host_writes, IMAGE_WORDS);
    check("b_sb_empty", sb.size(), 0);
    halt_after_50("b");

    // Run C: never halts, times out at 100 cycles
    stall = 0;
    push_image();
    pulse_start();
    wait_exec(5000);
    for (int i = 0; i < 300 && !error; i++) @(negedge clock);
    $display("c: done=%0d error=%0d run_cycles=%0d", done, error, run_cycles);
    check("c_error", error, 1);
    check("c_done", done, 0);
    check("c_execute", execute, 0);
    check("c_run_cycles", run_cycles, 100);

    // Run D: reset during word 37, then reload from word 0
    push_image();
    pulse_start();
    for (int i = 0; i < 5000 && !(host_writes == 37 && bus.host_write_req); i++)
      @(negedge clock);
    check("d_reached_word37", host_writes, 37);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midload_reset");
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    push_image();
    pulse_start();
    check("d_busy", busy, 1);
    wait_exec(5000);
    check("d_writes", host_writes, IMAGE_WORDS);
    check("d_sb_empty", sb.size(), 0);
    halt_after_50("d");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/block_program_loader.md
# block_program_loader

Hardware program loader that sits directly upstream of the processing-element block on its host MMIO port. On a start pulse it enables the block and streams a complete program image from a source word memory into the block: every PE's instruction words, then every PE's router-setting words, each mapped to the PE's memory-map slot. It then asserts execute, counts run cycles until halted, and reports done or timeout.

## Interface
- NUM_PES, 16: processing elements in the block; fixed 4x4 grid.
- INSTRUCTION_WORDS, 4*TIA_MAX_NUM_INSTRUCTIONS: MMIO words per PE instruction image.
- ROUTER_WORDS, TIA_ROUTER_SETTING_MEMORY_WORDS: router words per PE; 0 means the router phase is skipped (software-router builds).
- PE_SPACE_WORDS, TIA_NUM_PROCESSING_ELEMENT_ADDRESS_SPACE_WORDS: MMIO stride per PE slot.
- INSTRUCTION_BASE, TIA_CORE_INSTRUCTION_MEMORY_BASE_INDEX: instruction offset in a slot.
- ROUTER_BASE, TIA_ROUTER_BASE_INDEX: router offset in a slot.
- INDEX_WIDTH, TIA_MMIO_INDEX_WIDTH; DATA_WIDTH, TIA_MMIO_DATA_WIDTH.
- TIMEOUT_CYCLES, 1000000: maximum run cycles before error.
- clock  input  1  sole clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-low.
- start  input  1  one-cycle pulse; honoured only in IDLE, DONE or ERROR.
- source_read_req  output  1; source_read_index  output  INDEX_WIDTH; source_read_ack  input  1; source_read_data  input  DATA_WIDTH: source image port.
- host_write_req  output  1; host_write_index  output  INDEX_WIDTH; host_write_data  output  DATA_WIDTH; host_write_ack  input  1: block host port. Host read_req and read_index are driven 0 by the instantiating level.
- block_enable  output  1; block_execute  output  1; block_halted  input  1.
- busy, done, error  output  1 each: status.
- run_cycles  output  32: cycles with execute high in the last run.

## Operation
- Source layout: instruction word k of PE p at p*INSTRUCTION_WORDS+k; router word j of PE p at NUM_PES*INSTRUCTION_WORDS + p*ROUTER_WORDS + j.
- Slot mapping for PE p: row=p/4, col=p%4, quartet=2*(row/2)+col/2, sub=2*(row%2)+col%2, m=4*quartet+sub.
- Destinations: instructions at PE_SPACE_WORDS*m+INSTRUCTION_BASE+k; routers at PE_SPACE_WORDS*m+ROUTER_BASE+j.
- States: IDLE -> ENABLE -> FETCH <-> WRITE (until all words are written) -> START -> RUN -> DONE or ERROR.
- Order: all instruction words (p outer, k inner), then all router words (p outer, j inner).
- IDLE: all outputs 0. Start pulse: clear run_cycles, done and error; busy=1; go to ENABLE.
- ENABLE: drive block_enable=1 for one cycle; it stays high until reset.
- FETCH: hold source_read_req=1 with a stable index until ack is sampled high; capture data; drop req; go to WRITE.
- WRITE: hold host_write_req=1 with index and data stable until write_ack is sampled high; drop req for at least one cycle; advance counters.
- START: drive block_execute=1.
- RUN: increment run_cycles each cycle with execute high.
  - halted sampled high: execute goes 0, done=1, go to DONE.
  - run_cycles reaches TIMEOUT_CYCLES: execute goes 0, error=1, go to ERROR.
- DONE and ERROR: hold status and run_cycles; block_enable stays 1; start restarts the whole sequence.
- Start while busy: ignored.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; every output 0, including run_cycles and block_enable.
- Reset mid-load or mid-run drops every req and execute immediately; no partial-write recovery.
- Start sampled in cycle t gives busy=1 in t+1 and block_enable=1 in t+2.
- Read handshake: req rises the cycle after entering FETCH; ack sampled in cycle t drops req in t+1.
- Write handshake: ack sampled high in cycle t drops req in t+1; the next write req is no earlier than t+3.
- Ack high before req: treated as completing on the first cycle req is high (level ack permitted).
- Block throughput: minimum 4 cycles per word with single-cycle acks.
- Execute rises one cycle after the last write ack; halted is first sampled the cycle after execute rises.
- Halt and timeout in the same cycle: halt wins.
- run_cycles saturates at 2^32-1.

## Test plan
- Slot mapping (PE_SPACE_WORDS=64, INSTRUCTION_BASE=0, ROUTER_BASE=32, INSTRUCTION_WORDS=8, ROUTER_WORDS=2): the source word at index 43 (PE5, k=3) is written to host index 195; the source word at index 141 (router, PE6, j=1) is written to host index 417.
- Full image with 1-cycle acks: exactly 160 writes in the specified order, each with data equal to the source contents; execute rises after the 160th ack.
- Stalled acks (random 0-7 cycle delay): req, index and data hold stable while waiting; there are no duplicate or skipped writes.
- halted asserted 50 cycles after execute rises: done=1, run_cycles=50, execute=0; a second start reruns and rewrites all 160 words.
- halted never asserted with TIMEOUT_CYCLES=100: error=1, run_cycles=100, execute=0.
- reset pulled low during word 37: all outputs are 0 within the same cycle; after release, a start reloads from word 0.
